// File: rtl/saturation_pkg.sv
// Shared defaults and flag type for the multi-channel saturation block.
package saturation_pkg;

  localparam int unsigned IN_W_DEF  = 9;
  localparam int unsigned OUT_W_DEF = 8;
  localparam int unsigned NCH_DEF   = 4;
  localparam int unsigned CNT_W_DEF = 16;

  localparam int LIM_SUP_RST_DEF = 120;
  localparam int LIM_INF_RST_DEF = -120;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } sat_flag_t;

endpackage

// File: rtl/sat_lane.sv
// Single-channel combinational clamp: wide signed sample against signed thresholds.
module sat_lane
  import saturation_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic signed [IN_W-1:0]  x,
  input  logic signed [OUT_W-1:0] sup,
  input  logic signed [OUT_W-1:0] inf,
  output logic        [OUT_W-1:0] y,
  output sat_flag_t               flag
);

  logic signed [IN_W-1:0] sup_ext;
  logic signed [IN_W-1:0] inf_ext;

  assign sup_ext = IN_W'(sup);
  assign inf_ext = IN_W'(inf);

  // Between the thresholds the value fits OUT_W, so truncation is lossless.
  always_comb begin
    y    = x[OUT_W-1:0];
    flag = NONE;
    if (x > sup_ext) begin
      y    = sup;
      flag = HI;
    end else if (x < inf_ext) begin
      y    = inf;
      flag = LO;
    end
  end

endmodule

// File: rtl/saturation_mc.sv
// Multi-channel clamp with registered valid/ready output and saturating event counters.
// Optional macro SATURATION_MC_STICKY_EN adds a per-channel sticky saturation flag port.
module saturation_mc
  import saturation_pkg::*;
#(
  parameter int unsigned IN_W        = IN_W_DEF,
  parameter int unsigned OUT_W       = OUT_W_DEF,
  parameter int unsigned NCH         = NCH_DEF,
  parameter int          LIM_SUP_RST = LIM_SUP_RST_DEF,
  parameter int          LIM_INF_RST = LIM_INF_RST_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  localparam int unsigned SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*IN_W-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*OUT_W-1:0]    out_data,
  output logic [NCH-1:0]          sat_hi,
  output logic [NCH-1:0]          sat_lo,
  input  logic                    cfg_we,
  input  logic signed [OUT_W-1:0] cfg_sup,
  input  logic signed [OUT_W-1:0] cfg_inf,
  output logic                    cfg_err,
  input  logic                    cnt_clr,
  input  logic [SEL_W-1:0]        cnt_sel,
  output logic [CNT_W-1:0]        cnt_value
`ifdef SATURATION_MC_STICKY_EN
  ,
  output logic [NCH-1:0]          sat_sticky
`endif
);

  logic                    out_valid_q;
  logic [NCH*OUT_W-1:0]    out_data_q;
  logic [NCH-1:0]          sat_hi_q;
  logic [NCH-1:0]          sat_lo_q;
  logic signed [OUT_W-1:0] sup_q;
  logic signed [OUT_W-1:0] inf_q;
  logic                    cfg_err_q;
  logic [CNT_W-1:0]        cnt_q [NCH];

  logic [NCH*OUT_W-1:0]    lane_y;
  logic [NCH-1:0]          lane_hi;
  logic [NCH-1:0]          lane_lo;
  logic                    accept;
  logic                    xfer;
  logic                    cfg_ok;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;
  assign cfg_ok   = cfg_sup >= cfg_inf;

  for (genvar i = 0; i < NCH; i++) begin : gen_lane
    sat_flag_t flag;
    sat_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .x    (in_data[i*IN_W +: IN_W]),
      .sup  (sup_q),
      .inf  (inf_q),
      .y    (lane_y[i*OUT_W +: OUT_W]),
      .flag (flag)
    );
    assign lane_hi[i] = (flag == HI);
    assign lane_lo[i] = (flag == LO);
  end

  // Output register holds its beat until the downstream takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_hi_q    <= '0;
      sat_lo_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= lane_y;
      sat_hi_q    <= lane_hi;
      sat_lo_q    <= lane_lo;
    end else if (xfer) begin
      out_valid_q <= 1'b0;
    end
  end

  // The lanes see sup_q/inf_q before this edge, so a same-cycle beat uses the old limits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sup_q     <= OUT_W'(LIM_SUP_RST);
      inf_q     <= OUT_W'(LIM_INF_RST);
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        sup_q <= cfg_sup;
        inf_q <= cfg_inf;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cnt_clr) begin
          cnt_q[i] <= '0;
        end else if (xfer && (sat_hi_q[i] || sat_lo_q[i]) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    cnt_value = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_sel == SEL_W'(i)) cnt_value = cnt_q[i];
    end
  end

`ifdef SATURATION_MC_STICKY_EN
  logic [NCH-1:0] sticky_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= '0;
    end else if (cnt_clr) begin
      sticky_q <= '0;
    end else if (xfer) begin
      sticky_q <= sticky_q | sat_hi_q | sat_lo_q;
    end
  end

  assign sat_sticky = sticky_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_hi    = sat_hi_q;
  assign sat_lo    = sat_lo_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_saturation_mc.sv
// Scoreboard bench for saturation_mc: directed scenarios plus randomized traffic.
module tb_saturation_mc;

  localparam int IN_W  = 9;
  localparam int OUT_W = 8;
  localparam int NCH   = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  hi;
    logic [3:0]  lo;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [35:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [3:0]        sat_hi;
  logic [3:0]        sat_lo;
  logic              cfg_we;
  logic signed [7:0] cfg_sup;
  logic signed [7:0] cfg_inf;
  logic              cfg_err;
  logic              cnt_clr;
  logic [1:0]        cnt_sel;
  logic [3:0]        cnt_value;
`ifdef SATURATION_MC_STICKY_EN
  logic [3:0]        sat_sticky;
`endif

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sb[$];
  int    sup_m = 120;
  int    inf_m = -120;
  int    cnt_m [NCH];
  logic [3:0] sticky_m = '0;
  bit    exp_err = 1'b0;

  saturation_mc #(
    .IN_W        (IN_W),
    .OUT_W       (OUT_W),
    .NCH         (NCH),
    .LIM_SUP_RST (120),
    .LIM_INF_RST (-120),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_hi    (sat_hi),
    .sat_lo    (sat_lo),
    .cfg_we    (cfg_we),
    .cfg_sup   (cfg_sup),
    .cfg_inf   (cfg_inf),
    .cfg_err   (cfg_err),
    .cnt_clr   (cnt_clr),
    .cnt_sel   (cnt_sel),
    .cnt_value (cnt_value)
`ifdef SATURATION_MC_STICKY_EN
    ,
    .sat_sticky (sat_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference clamp: plain integer min/max against the current limits.
  function automatic beat_t model(input logic [35:0] d, input int sup, input int inf);
    beat_t b;
    int x;
    int y;
    b = '0;
    for (int c = 0; c < NCH; c++) begin
      x = int'($signed(d[c*IN_W +: IN_W]));
      y = x;
      if (x > sup) begin
        y = sup;
        b.hi[c] = 1'b1;
      end else if (x < inf) begin
        y = inf;
        b.lo[c] = 1'b1;
      end
      b.data[c*OUT_W +: OUT_W] = y[7:0];
    end
    return b;
  endfunction

  function automatic logic [35:0] pack4(input int a, input int b, input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  // Recorder: captures accepted beats and threshold writes as the DUT sees them.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        sup_m   = 120;
        inf_m   = -120;
        exp_err = 1'b0;
      end else begin
        chk("cfg_err", cfg_err, exp_err);
        if (in_valid && in_ready) sb.push_back(model(in_data, sup_m, inf_m));
        exp_err = 1'b0;
        if (cfg_we) begin
          if (int'(cfg_sup) >= int'(cfg_inf)) begin
            sup_m = int'(cfg_sup);
            inf_m = int'(cfg_inf);
          end else begin
            exp_err = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compares presented beats with the scoreboard and tracks the counters.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        sb.delete();
        for (int c = 0; c < NCH; c++) cnt_m[c] = 0;
        sticky_m = '0;
      end else begin
        chk("cnt_value", cnt_value, cnt_m[cnt_sel]);
`ifdef SATURATION_MC_STICKY_EN
        chk("sat_sticky", sat_sticky, sticky_m);
`endif
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("spurious_valid", out_valid, 1'b0);
          end else begin
            e = sb[0];
            chk("out_data", out_data, e.data);
            chk("sat_hi", sat_hi, e.hi);
            chk("sat_lo", sat_lo, e.lo);
            if (out_ready) begin
              void'(sb.pop_front());
              for (int c = 0; c < NCH; c++) begin
                if ((e.hi[c] || e.lo[c]) && cnt_m[c] < CMAX) cnt_m[c]++;
                if (e.hi[c] || e.lo[c]) sticky_m[c] = 1'b1;
              end
            end
          end
        end
        if (cnt_clr) begin
          for (int c = 0; c < NCH; c++) cnt_m[c] = 0;
          sticky_m = '0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0; cnt_clr = 1'b0;
    in_data = '0; cfg_sup = '0; cfg_inf = '0; cnt_sel = '0;
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_sat_hi", sat_hi, 4'h0);
    chk("rst_sat_lo", sat_lo, 4'h0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    for (int s = 0; s < NCH; s++) begin
      cnt_sel = 2'(s);
      #1;
      chk("rst_cnt", cnt_value, 4'h0);
    end
    tick(); tick();
    reset = 1'b1;

    // Default limits, one beat, latency 1.
    tick();
    in_valid = 1'b1; in_data = pack4(130, -130, 120, 5);
    tick();
    in_valid = 1'b0;
    chk("lat_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 32'h05788878);
    chk("t1_hi", sat_hi, 4'b0001);
    chk("t1_lo", sat_lo, 4'b0010);
    tick();

    // Threshold write alongside a beat: that beat still sees the old limits.
    cfg_we = 1'b1; cfg_sup = 8'sd50; cfg_inf = -8'sd50;
    in_valid = 1'b1; in_data = pack4(60, -60, 50, -50);
    tick();
    cfg_we = 1'b0;
    chk("t2_old", out_data, 32'hCE32C43C);
    tick();
    in_valid = 1'b0;
    chk("t2_new", out_data, 32'hCE32CE32);
    chk("t2_hi", sat_hi, 4'b0001);
    chk("t2_lo", sat_lo, 4'b0010);
    tick();

    // Restore defaults, then an inverted write must be rejected.
    cfg_we = 1'b1; cfg_sup = 8'sd120; cfg_inf = -8'sd120;
    tick();
    cfg_sup = -8'sd10; cfg_inf = 8'sd10;
    tick();
    cfg_we = 1'b0;
    chk("t3_err_pulse", cfg_err, 1'b1);
    in_valid = 1'b1; in_data = pack4(130, -130, 120, 5);
    tick();
    in_valid = 1'b0;
    chk("t3_err_clear", cfg_err, 1'b0);
    chk("t3_kept", out_data, 32'h05788878);
    tick();

    // Backpressure for five cycles with input pending.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 36'({$urandom(), $urandom()});
      tick();
      chk("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 36'({$urandom(), $urandom()});
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();

    // Counter saturation on channel 2, then clear racing a saturating transfer.
    cnt_sel = 2'd2; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; in_valid = 1'b1; in_data = pack4(0, 0, 200, 0);
    repeat (20) tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("cnt_sat15", cnt_value, 4'd15);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", cnt_value, 4'd0);
    tick();

    // Randomized traffic with occasional reconfiguration and clears.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom() % 4) != 0;
      out_ready = ($urandom() % 4) != 0;
      in_data   = 36'({$urandom(), $urandom()});
      cfg_we    = ($urandom() % 16) == 0;
      cfg_sup   = 8'($urandom());
      cfg_inf   = 8'($urandom());
      cnt_clr   = ($urandom() % 32) == 0;
      cnt_sel   = 2'($urandom());
      tick();
    end
    cfg_we = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();

    // Asynchronous reset in the middle of a stalled burst.
    cnt_sel = 2'd2; in_valid = 1'b1; in_data = pack4(0, 0, 255, 0);
    tick(); tick();
    out_ready = 1'b0;
    tick(); tick();
    chk("pre_reset_valid", out_valid, 1'b1);
    #2;
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_cnt", cnt_value, 4'h0);
    tick();
    reset = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = pack4(130, -130, 120, 5);
    tick();
    in_valid = 1'b0;
    chk("post_rst_limits", out_data, 32'h05788878);
    tick(); tick(); tick();

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/saturation_mc.md
Name: saturation_mc

Overview:
- Multi-channel, parametrised successor of the team's single-channel clipper.
- Clamps NCH signed samples per beat to runtime-programmable thresholds.
- Registered output with valid/ready handshake; per-channel saturation event counters.
- Sits between the arithmetic datapath (wide results) and the narrower output/DAC stage.

Parameters:
- IN_W, 9, signed input sample width per channel
- OUT_W, 8, signed output sample width per channel (OUT_W <= IN_W)
- NCH, 4, number of parallel channels
- LIM_SUP_RST, 120, upper threshold after reset (signed OUT_W)
- LIM_INF_RST, -120, lower threshold after reset (signed OUT_W)
- CNT_W, 16, width of each per-channel saturation counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  NCH*IN_W  packed signed samples, channel 0 in LSBs
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  NCH*OUT_W  packed clamped samples, channel 0 in LSBs
- sat_hi  out  NCH  per-channel: current output beat was clamped to upper threshold
- sat_lo  out  NCH  per-channel: current output beat was clamped to lower threshold
- cfg_we  in  1  load new thresholds
- cfg_sup  in  OUT_W  new upper threshold, signed
- cfg_inf  in  OUT_W  new lower threshold, signed
- cfg_err  out  1  one-cycle pulse: write rejected
- cnt_clr  in  1  synchronous clear of all counters
- cnt_sel  in  $clog2(NCH)  counter readback select
- cnt_value  out  CNT_W  counter of selected channel, combinational read of registers

Behaviour:
- Reset (reset=0, async): out_valid=0, out_data=0, sat_hi=sat_lo=0, cfg_err=0, all counters=0, thresholds=LIM_SUP_RST/LIM_INF_RST.
- Handshake: in_ready = !out_valid || out_ready. Beat accepted when in_valid && in_ready; result appears on out_data/out_valid next cycle (latency 1).
- out_data, sat_hi, sat_lo held stable while out_valid && !out_ready. out_valid drops only after a transfer with no new beat accepted.
- Back-to-back beats at full rate when out_ready held 1.
- Per channel, compare sign-extended IN_W values: x > sup -> sup, sat_hi=1; x < inf -> inf, sat_lo=1; else x truncated to OUT_W (lossless, since inf <= x <= sup).
- Comparison is strict; x equal to a threshold passes unflagged.
- cfg_we: if cfg_sup >= cfg_inf (signed), thresholds update at the edge and apply to beats accepted from the next cycle on. Otherwise thresholds are kept and cfg_err pulses 1 cycle.
- cfg_we in the same cycle as an accepted beat: that beat uses the old thresholds.
- Counters: on each output transfer (out_valid && out_ready), channel counter increments if sat_hi|sat_lo for that channel. Counters saturate at 2^CNT_W-1 (no wrap).
- cnt_clr wins over a simultaneous increment (counter reads 0 next cycle).
- Reset mid-stream: the pending output beat is discarded; nothing is replayed.

Optional Feature:
- Macro SATURATION_MC_STICKY_EN.
- Defined: adds output port sat_sticky [NCH], a per-channel sticky OR of sat_hi|sat_lo over transferred beats. Cleared by reset and cnt_clr; clear wins over a simultaneous set.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package saturation_pkg: default widths, LIM_SUP_RST/LIM_INF_RST constants, typedef sat_flag_t (enum NONE/HI/LO).
- One sub-module sat_lane: single-channel combinational clamp (IN_W, OUT_W, sup, inf -> value, flag). Generated NCH times.
- Top holds the handshake register, threshold registers and counters.

Test Plan:
- Reset defaults, channels (130, -130, 120, 5) -> out (120, -120, 120, 5); sat_hi=0001, sat_lo=0010; out_valid 1 cycle after accept.
- cfg_we sup=50, inf=-50, beat (60, -60, 50, -50) accepted same cycle -> old limits (60, -60, 50, -50); next beat identical -> (50, -50, 50, -50).
- cfg_we sup=-10, inf=10 -> cfg_err pulse, limits stay 120/-120.
- out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable; release -> beats in order, none lost or duplicated.
- CNT_W=4, 20 saturating transfers on ch2 -> cnt_value=15 with cnt_sel=2; cnt_clr with simultaneous saturating transfer -> 0.
- Async reset asserted mid-burst with out_valid=1 -> out_valid=0 immediately, counters 0, limits back to defaults.
